// File: rtl/fetch_pkg.sv
// Shared fetch constants and PC helpers for the instruction fetch unit.
package fetch_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Sequential PC wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction FIFO with flush; flush takes priority over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    input  logic            flush,
    output logic [XLEN-1:0] head_data,
    output logic [CW-1:0]   count
);
    logic [XLEN-1:0] mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push) - CW'(pop);
        end
    end

    // Head and occupancy views.
    always_comb begin
        head_data = mem_r[rd_ptr_r];
        count     = count_r;
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited imem requests, in-order response buffering,
// redirect with flush and discard of stale in-flight responses.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc
);
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] head_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   discard_cnt_r;

    logic [CW-1:0]   q_count_s;
    logic [XLEN-1:0] q_head_s;
    logic            pop_s;
    logic            push_s;
    logic            req_fire_s;
    logic [CW:0]     inflight_s;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (imem_rsp_data),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head_data (q_head_s),
        .count     (q_count_s)
    );

    // Handshake qualification and output views; outputs are held at reset values while reset is low.
    always_comb begin
        instr_valid    = reset & !redirect_valid & (q_count_s != {CW{1'b0}});
        pop_s          = instr_valid & instr_ready;
        // Slots freed by this cycle's pop may be reused immediately for a new request.
        inflight_s     = {1'b0, outstanding_r} + {1'b0, q_count_s} - {{CW{1'b0}}, pop_s};
        imem_req_valid = reset & !redirect_valid & (inflight_s < (CW+1)'(DEPTH));
        req_fire_s     = imem_req_valid & imem_req_ready;
        push_s         = imem_rsp_valid & !redirect_valid & (discard_cnt_r == {CW{1'b0}});
        if (reset) begin
            imem_req_addr = fetch_pc_r;
            instr_pc      = head_pc_r;
            instr_data    = q_head_s;
        end else begin
            imem_req_addr = RESET_PC;
            instr_pc      = RESET_PC;
            instr_data    = 32'h0000_0000;
        end
    end

    // PC tracking and in-flight / discard accounting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_r    <= RESET_PC;
            head_pc_r     <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            discard_cnt_r <= {CW{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r    <= word_align(redirect_pc);
            head_pc_r     <= word_align(redirect_pc);
            // Everything still in flight after this cycle's response is stale.
            outstanding_r <= outstanding_r - CW'(imem_rsp_valid);
            discard_cnt_r <= outstanding_r - CW'(imem_rsp_valid);
        end else begin
            if (req_fire_s) begin
                fetch_pc_r <= next_pc(fetch_pc_r);
            end
            if (pop_s) begin
                head_pc_r <= next_pc(head_pc_r);
            end
            outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (discard_cnt_r != {CW{1'b0}})) begin
                discard_cnt_r <= discard_cnt_r - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-configurable memory model and a
// transaction-level scoreboard checking every cycle.
module tb_instr_fetch;
    localparam int DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic reset, redirect_valid, imem_req_valid, imem_req_ready;
    logic imem_rsp_valid, instr_valid, instr_ready;
    logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, instr_data, instr_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        pend[$];
    int          lat = 1;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          buffered = 0;
    int          req_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic        prev_rst = 1'b0;
    logic [31:0] exp_pc, exp_req;
    logic [31:0] req_addrs[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Memory model and per-cycle scoreboard: drive response at negedge+1, check at negedge+2.
    initial begin
        req_t r;
        logic exp_iv, pop_e, exp_rv;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        exp_pc  = RESET_PC;
        exp_req = RESET_PC;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (!reset) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0000_0000;
            end else if (pend.size() > 0 && pend[0].due == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend[0].addr ^ KEY;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            #1;
            if (reset && !prev_rst) rel_cyc = cyc;
            prev_rst = reset;
            if (!reset) begin
                chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
                chk("rst_instr_valid", 32'(instr_valid), 32'd0);
                chk("rst_req_addr", imem_req_addr, RESET_PC);
                chk("rst_instr_pc", instr_pc, RESET_PC);
                chk("rst_instr_data", instr_data, 32'h0000_0000);
                exp_pc   = RESET_PC;
                exp_req  = RESET_PC;
                buffered = 0;
            end else if (redirect_valid) begin
                chk("redir_instr_valid", 32'(instr_valid), 32'd0);
                chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
                if (imem_rsp_valid) r = pend.pop_front();
                foreach (pend[i]) pend[i].stale = 1'b1;
                buffered = 0;
                exp_pc   = redirect_pc & ~32'h3;
                exp_req  = redirect_pc & ~32'h3;
            end else begin
                exp_iv = (buffered > 0);
                pop_e  = exp_iv && instr_ready;
                exp_rv = (pend.size() + buffered - (pop_e ? 1 : 0)) < DEPTH;
                chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
                chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
                if (instr_valid) begin
                    chk("instr_pc", instr_pc, exp_pc);
                    chk("instr_data", instr_data, exp_pc ^ KEY);
                end
                if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
                if (imem_rsp_valid) begin
                    r = pend.pop_front();
                    if (!r.stale) buffered++;
                end
                if (instr_valid && instr_ready) begin
                    got_pc.push_back(instr_pc);
                    got_data.push_back(instr_data);
                    got_cyc.push_back(cyc);
                    buffered--;
                    exp_pc = exp_pc + 32'd4;
                end
                if (imem_req_valid && imem_req_ready) begin
                    r.addr  = imem_req_addr;
                    r.due   = cyc + lat;
                    r.stale = 1'b0;
                    pend.push_back(r);
                    req_addrs.push_back(imem_req_addr);
                    req_cnt++;
                    exp_req = exp_req + 32'd4;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        got_pc.delete();
        got_data.delete();
        got_cyc.delete();
        req_addrs.delete();
        req_cnt = 0;
    endtask

    task automatic apply_reset(input int lat_v, input logic rdy_v);
        @(negedge clk);
        reset = 1'b0; redirect_valid = 1'b0; instr_ready = rdy_v;
        imem_req_ready = 1'b1; lat = lat_v;
        cycles(2);
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic wait_got(input int n, input int budget, input string nm);
        for (int i = 0; i < budget && got_pc.size() < n; i++) @(negedge clk);
        chk(nm, 32'(got_pc.size() >= n), 32'd1);
    endtask

    // Directed stimulus.
    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
        instr_ready = 1'b1; imem_req_ready = 1'b1;

        // T1: streaming from reset with 1-cycle memory
        apply_reset(1, 1'b1);
        #3;
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0000_0000);
        wait_got(6, 20, "t1_wait");
        for (int i = 0; i < 6; i++) chk("t1_pc", got_pc[i], 32'(4 * i));
        chk("t1_data2", got_data[2], 32'hA5A5_A5AD);
        chk("t1_first_cycle", 32'(got_cyc[0] - rel_cyc), 32'd2);
        chk("t1_rate", 32'(got_cyc[5] - got_cyc[0]), 32'd5);
        @(negedge clk); imem_req_ready = 1'b0;
        cycles(3);
        imem_req_ready = 1'b1;
        cycles(8);

        // T2: decode stalled -> exactly DEPTH requests issued
        apply_reset(1, 1'b0);
        cycles(10);
        #3;
        chk("t2_req_cnt", 32'(req_cnt), 32'd2);
        chk("t2_req0", req_addrs[0], 32'h0000_0000);
        chk("t2_req1", req_addrs[1], 32'h0000_0004);
        chk("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
        @(negedge clk); instr_ready = 1'b1;
        wait_got(3, 20, "t2_wait");
        chk("t2_pc0", got_pc[0], 32'h0000_0000);
        chk("t2_pc1", got_pc[1], 32'h0000_0004);
        chk("t2_pc2", got_pc[2], 32'h0000_0008);
        chk("t2_gap01", 32'((got_cyc[1] - got_cyc[0]) <= 2), 32'd1);
        chk("t2_gap12", 32'((got_cyc[2] - got_cyc[1]) <= 2), 32'd1);

        // T3: 3-cycle memory, redirect with two requests in flight
        apply_reset(3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        #3;
        chk("t3_inflight", 32'(pend.size()), 32'd2);
        @(negedge clk); redirect_valid = 1'b0;
        clear_logs();
        wait_got(2, 30, "t3_wait");
        chk("t3_pc0", got_pc[0], 32'h0000_0100);
        chk("t3_data0", got_data[0], 32'hA5A5_A4A5);
        chk("t3_pc1", got_pc[1], 32'h0000_0104);

        // T4: redirect to unaligned target coinciding with a response and a handshake
        apply_reset(1, 1'b1);
        wait_got(4, 20, "t4_prewait");
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        clear_logs();
        #3;
        chk("t4_rsp_same_cycle", 32'(imem_rsp_valid), 32'd1);
        chk("t4_no_deliver", 32'(instr_valid), 32'd0);
        @(negedge clk); redirect_valid = 1'b0;
        wait_got(2, 20, "t4_wait");
        chk("t4_pc0", got_pc[0], 32'h0000_0200);
        chk("t4_data0", got_data[0], 32'hA5A5_A7A5);
        chk("t4_pc1", got_pc[1], 32'h0000_0204);

        // T5: PC wrap at top of address space
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        clear_logs();
        @(negedge clk); redirect_valid = 1'b0;
        wait_got(3, 20, "t5_wait");
        chk("t5_pc0", got_pc[0], 32'hFFFF_FFF8);
        chk("t5_data0", got_data[0], 32'h5A5A_5A5D);
        chk("t5_pc1", got_pc[1], 32'hFFFF_FFFC);
        chk("t5_data1", got_data[1], 32'h5A5A_5A59);
        chk("t5_pc2", got_pc[2], 32'h0000_0000);
        chk("t5_data2", got_data[2], 32'hA5A5_A5A5);

        // T6: reset mid-stream with the queue full
        @(negedge clk); instr_ready = 1'b0;
        cycles(6);
        #3;
        chk("t6_full_valid", 32'(instr_valid), 32'd1);
        chk("t6_full_no_req", 32'(imem_req_valid), 32'd0);
        @(negedge clk); reset = 1'b0;
        clear_logs();
        @(negedge clk); reset = 1'b1;
        #3;
        chk("t6_instr_valid", 32'(instr_valid), 32'd0);
        chk("t6_req_addr", imem_req_addr, RESET_PC);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk); instr_ready = 1'b1;
        wait_got(2, 20, "t6_wait");
        chk("t6_pc0", got_pc[0], 32'h0000_0000);
        chk("t6_pc1", got_pc[1], 32'h0000_0004);

        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
